// File: rtl/axil_bus_decoder_if.sv
// AXI4-Lite decoder bundle: one upstream slave channel set plus the flattened
// downstream vectors (slice i of every m_axi_* vector belongs to port i).
interface axil_bus_decoder_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int RESP_WIDTH  = 3,
  parameter int NUM_MASTERS = 4
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]             s_axi_awaddr;
  logic                              s_axi_awvalid;
  logic                              s_axi_awready;
  logic [DATA_WIDTH-1:0]             s_axi_wdata;
  logic [STRB_WIDTH-1:0]             s_axi_wstrb;
  logic                              s_axi_wvalid;
  logic                              s_axi_wready;
  logic [RESP_WIDTH-1:0]             s_axi_bresp;
  logic                              s_axi_bvalid;
  logic                              s_axi_bready;
  logic [ADDR_WIDTH-1:0]             s_axi_araddr;
  logic                              s_axi_arvalid;
  logic                              s_axi_arready;
  logic [DATA_WIDTH-1:0]             s_axi_rdata;
  logic [RESP_WIDTH-1:0]             s_axi_rresp;
  logic                              s_axi_rvalid;
  logic                              s_axi_rready;

  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [NUM_MASTERS-1:0]            m_axi_awvalid;
  logic [NUM_MASTERS-1:0]            m_axi_awready;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_axi_wdata;
  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_axi_wstrb;
  logic [NUM_MASTERS-1:0]            m_axi_wvalid;
  logic [NUM_MASTERS-1:0]            m_axi_wready;
  logic [NUM_MASTERS*RESP_WIDTH-1:0] m_axi_bresp;
  logic [NUM_MASTERS-1:0]            m_axi_bvalid;
  logic [NUM_MASTERS-1:0]            m_axi_bready;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_axi_araddr;
  logic [NUM_MASTERS-1:0]            m_axi_arvalid;
  logic [NUM_MASTERS-1:0]            m_axi_arready;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_axi_rdata;
  logic [NUM_MASTERS*RESP_WIDTH-1:0] m_axi_rresp;
  logic [NUM_MASTERS-1:0]            m_axi_rvalid;
  logic [NUM_MASTERS-1:0]            m_axi_rready;

  // Decoder side
  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
           m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
           m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
  );

  // Environment side: upstream master plus downstream slaves
  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
           m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
           m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/axil_bus_decoder.sv
// AXI4-Lite 1-to-N address decoder: routes by addr >> REGION_SHIFT, answers
// DECERR for unmapped regions and SLVERR when a downstream port stalls too long.
module axil_bus_decoder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int RESP_WIDTH     = 3,
  parameter int NUM_MASTERS    = 4,
  parameter int REGION_SHIFT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               axi_aclk,
  input logic               axi_areset,
  axil_bus_decoder_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);
  localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_WAITB, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAITR, R_RESP} r_state_t;

  logic [ADDR_WIDTH-1:0] aw_region, ar_region;
  logic                  aw_mapped, ar_mapped;

  assign aw_region = bus.s_axi_awaddr >> REGION_SHIFT;
  assign ar_region = bus.s_axi_araddr >> REGION_SHIFT;
  assign aw_mapped = aw_region < ADDR_WIDTH'(NUM_MASTERS);
  assign ar_mapped = ar_region < ADDR_WIDTH'(NUM_MASTERS);

  // ---------------- write path ----------------
  w_state_t               w_state, w_state_next;
  logic [IDX_W-1:0]       w_idx;
  logic [ADDR_WIDTH-1:0]  w_awaddr;
  logic [DATA_WIDTH-1:0]  w_wdata;
  logic [STRB_WIDTH-1:0]  w_wstrb;
  logic [RESP_WIDTH-1:0]  w_bresp;
  logic [CNT_W-1:0]       w_cnt;
  logic                   aw_pend, w_pend;
  logic                   w_accept, aw_hs, w_hs, w_got_b, w_timeout;
  logic [NUM_MASTERS-1:0] w_sel;

  always_comb begin
    w_state_next = w_state;
    w_accept     = 1'b0;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    w_got_b      = 1'b0;
    w_timeout    = 1'b0;
    case (w_state)
      W_IDLE: begin
        w_accept = bus.s_axi_awvalid & bus.s_axi_wvalid & ~axi_areset;
        if (w_accept) w_state_next = aw_mapped ? W_FWD : W_RESP;
      end
      W_FWD: begin
        aw_hs = aw_pend & bus.m_axi_awready[w_idx];
        w_hs  = w_pend & bus.m_axi_wready[w_idx];
        if ((~aw_pend | aw_hs) & (~w_pend | w_hs)) begin
          w_state_next = W_WAITB;
        end else if (w_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = W_RESP;
        end
      end
      W_WAITB: begin
        w_got_b = bus.m_axi_bvalid[w_idx];
        if (w_got_b) begin
          w_state_next = W_RESP;
        end else if (w_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = W_RESP;
        end
      end
      W_RESP:  if (bus.s_axi_bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      w_state  <= W_IDLE;
      w_idx    <= '0;
      w_awaddr <= '0;
      w_wdata  <= '0;
      w_wstrb  <= '0;
      w_bresp  <= '0;
      w_cnt    <= '0;
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
    end else begin
      w_state <= w_state_next;
      if (w_accept) begin
        w_idx    <= aw_region[IDX_W-1:0];
        w_awaddr <= bus.s_axi_awaddr;
        w_wdata  <= bus.s_axi_wdata;
        w_wstrb  <= bus.s_axi_wstrb;
        w_bresp  <= aw_mapped ? '0 : RESP_DECERR;
        w_cnt    <= '0;
        aw_pend  <= aw_mapped;
        w_pend   <= aw_mapped;
      end
      if (w_state == W_FWD || w_state == W_WAITB) w_cnt <= w_cnt + CNT_W'(1);
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;
      if (w_got_b) w_bresp <= bus.m_axi_bresp[w_idx*RESP_WIDTH +: RESP_WIDTH];
      if (w_timeout) begin
        w_bresp <= RESP_SLVERR;
        aw_pend <= 1'b0;
        w_pend  <= 1'b0;
      end
    end
  end

  // Address/data are broadcast; only the selected slice ever sees a valid.
  assign w_sel             = NUM_MASTERS'(1) << w_idx;
  assign bus.s_axi_awready = w_accept;
  assign bus.s_axi_wready  = w_accept;
  assign bus.s_axi_bvalid  = (w_state == W_RESP);
  assign bus.s_axi_bresp   = w_bresp;
  assign bus.m_axi_awvalid = (w_state == W_FWD && aw_pend) ? w_sel : '0;
  assign bus.m_axi_wvalid  = (w_state == W_FWD && w_pend) ? w_sel : '0;
  assign bus.m_axi_bready  = (w_state == W_WAITB) ? w_sel : '0;
  assign bus.m_axi_awaddr  = {NUM_MASTERS{w_awaddr}};
  assign bus.m_axi_wdata   = {NUM_MASTERS{w_wdata}};
  assign bus.m_axi_wstrb   = {NUM_MASTERS{w_wstrb}};

  // ---------------- read path ----------------
  r_state_t               r_state, r_state_next;
  logic [IDX_W-1:0]       r_idx;
  logic [ADDR_WIDTH-1:0]  r_araddr;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [RESP_WIDTH-1:0]  r_rresp;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_accept, r_got_r, r_timeout;
  logic [NUM_MASTERS-1:0] r_sel;

  always_comb begin
    r_state_next = r_state;
    r_accept     = 1'b0;
    r_got_r      = 1'b0;
    r_timeout    = 1'b0;
    case (r_state)
      R_IDLE: begin
        r_accept = bus.s_axi_arvalid & ~axi_areset;
        if (r_accept) r_state_next = ar_mapped ? R_FWD : R_RESP;
      end
      R_FWD: begin
        if (bus.m_axi_arready[r_idx]) begin
          r_state_next = R_WAITR;
        end else if (r_cnt == CNT_LAST) begin
          r_timeout    = 1'b1;
          r_state_next = R_RESP;
        end
      end
      R_WAITR: begin
        r_got_r = bus.m_axi_rvalid[r_idx];
        if (r_got_r) begin
          r_state_next = R_RESP;
        end else if (r_cnt == CNT_LAST) begin
          r_timeout    = 1'b1;
          r_state_next = R_RESP;
        end
      end
      R_RESP:  if (bus.s_axi_rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_state  <= R_IDLE;
      r_idx    <= '0;
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= r_state_next;
      if (r_accept) begin
        r_idx    <= ar_region[IDX_W-1:0];
        r_araddr <= bus.s_axi_araddr;
        r_rdata  <= '0;
        r_rresp  <= ar_mapped ? '0 : RESP_DECERR;
        r_cnt    <= '0;
      end
      if (r_state == R_FWD || r_state == R_WAITR) r_cnt <= r_cnt + CNT_W'(1);
      if (r_got_r) begin
        r_rdata <= bus.m_axi_rdata[r_idx*DATA_WIDTH +: DATA_WIDTH];
        r_rresp <= bus.m_axi_rresp[r_idx*RESP_WIDTH +: RESP_WIDTH];
      end
      if (r_timeout) begin
        r_rdata <= '0;
        r_rresp <= RESP_SLVERR;
      end
    end
  end

  assign r_sel             = NUM_MASTERS'(1) << r_idx;
  assign bus.s_axi_arready = r_accept;
  assign bus.s_axi_rvalid  = (r_state == R_RESP);
  assign bus.s_axi_rdata   = r_rdata;
  assign bus.s_axi_rresp   = r_rresp;
  assign bus.m_axi_arvalid = (r_state == R_FWD) ? r_sel : '0;
  assign bus.m_axi_rready  = (r_state == R_WAITR) ? r_sel : '0;
  assign bus.m_axi_araddr  = {NUM_MASTERS{r_araddr}};
endmodule

// File: tb/tb_axil_bus_decoder.sv
// Directed bench for axil_bus_decoder: routing, latency, DECERR, SLVERR timeout,
// concurrent read/write and asynchronous reset mid-transaction.
`timescale 1ns/1ps
module tb_axil_bus_decoder;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int NM = 4;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_wait;

  always #5 clk = ~clk;

  axil_bus_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .NUM_MASTERS(NM)) bus ();

  axil_bus_decoder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .NUM_MASTERS(NM),
    .REGION_SHIFT(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .axi_aclk  (clk),
    .axi_areset(rst),
    .bus       (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0;
    bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    bus.m_axi_awready = '0; bus.m_axi_wready = '0; bus.m_axi_bresp = '0;
    bus.m_axi_bvalid = '0; bus.m_axi_arready = '0; bus.m_axi_rdata = '0;
    bus.m_axi_rresp = '0; bus.m_axi_rvalid = '0;

    // Reset state; upstream valids must not be accepted while in reset
    repeat (2) @(posedge clk);
    #1;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
    #1;
    chk("rst_awready", bus.s_axi_awready, 0);
    chk("rst_arready", bus.s_axi_arready, 0);
    chk("rst_bvalid",  bus.s_axi_bvalid, 0);
    chk("rst_rvalid",  bus.s_axi_rvalid, 0);
    chk("rst_rdata",   bus.s_axi_rdata, 0);
    chk("rst_m_awvalid", bus.m_axi_awvalid, 0);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    rst = 1'b0;
    step();

    // Awvalid alone is never accepted
    bus.s_axi_awvalid = 1'b1;
    #1;
    chk("aw_only_awready", bus.s_axi_awready, 0);
    bus.s_axi_awvalid = 1'b0;
    step();

    // Write 0x00 -> port0, zero-wait downstream
    bus.m_axi_awready[0] = 1'b1; bus.m_axi_wready[0] = 1'b1;
    bus.m_axi_bvalid[0] = 1'b1;  bus.m_axi_bresp[0*RW +: RW] = 3'd0;
    bus.s_axi_awaddr = 8'h00; bus.s_axi_wdata = 32'd56; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    #1;
    chk("w0_awready", bus.s_axi_awready, 1);
    chk("w0_wready",  bus.s_axi_wready, 1);
    step();
    chk("w0_m_awvalid", bus.m_axi_awvalid, 4'b0001);
    chk("w0_m_wvalid",  bus.m_axi_wvalid, 4'b0001);
    chk("w0_m_awaddr",  bus.m_axi_awaddr[0*AW +: AW], 8'h00);
    chk("w0_m_wdata",   bus.m_axi_wdata[0*DW +: DW], 32'd56);
    chk("w0_m_wstrb",   bus.m_axi_wstrb[0*SW +: SW], 4'hF);
    chk("w0_busy_awready", bus.s_axi_awready, 0);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    step();
    chk("w0_m_bready", bus.m_axi_bready, 4'b0001);
    chk("w0_valids_dropped", bus.m_axi_awvalid, 4'b0000);
    step();
    chk("w0_bvalid_k3", bus.s_axi_bvalid, 1);
    chk("w0_bresp", bus.s_axi_bresp, 0);
    step();
    chk("w0_bvalid_held", bus.s_axi_bvalid, 1);
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    chk("w0_bvalid_clr", bus.s_axi_bvalid, 0);
    bus.m_axi_awready = '0; bus.m_axi_wready = '0; bus.m_axi_bvalid = '0;

    // Read 24 -> port1, rdata 76
    bus.m_axi_arready[1] = 1'b1; bus.m_axi_rvalid[1] = 1'b1;
    bus.m_axi_rdata[1*DW +: DW] = 32'd76; bus.m_axi_rresp[1*RW +: RW] = 3'd0;
    bus.s_axi_araddr = 8'd24; bus.s_axi_arvalid = 1'b1;
    #1;
    chk("r1_arready", bus.s_axi_arready, 1);
    step();
    bus.s_axi_arvalid = 1'b0;
    chk("r1_m_arvalid", bus.m_axi_arvalid, 4'b0010);
    chk("r1_m_araddr",  bus.m_axi_araddr[1*AW +: AW], 8'd24);
    step();
    chk("r1_m_rready", bus.m_axi_rready, 4'b0010);
    step();
    chk("r1_rvalid_k3", bus.s_axi_rvalid, 1);
    chk("r1_rdata", bus.s_axi_rdata, 32'd76);
    chk("r1_rresp", bus.s_axi_rresp, 0);
    step();
    chk("r1_rvalid_held", bus.s_axi_rvalid, 1);
    chk("r1_rdata_held", bus.s_axi_rdata, 32'd76);
    bus.s_axi_rready = 1'b1;
    step();
    bus.s_axi_rready = 1'b0;
    chk("r1_rvalid_clr", bus.s_axi_rvalid, 0);
    bus.m_axi_arready = '0; bus.m_axi_rvalid = '0;

    // Unmapped read 0x40 and write 0x50 -> DECERR with no downstream activity
    bus.s_axi_araddr = 8'h40; bus.s_axi_arvalid = 1'b1;
    step();
    bus.s_axi_arvalid = 1'b0;
    chk("dec_r_rvalid", bus.s_axi_rvalid, 1);
    chk("dec_r_rresp", bus.s_axi_rresp, 3);
    chk("dec_r_rdata", bus.s_axi_rdata, 0);
    chk("dec_r_m_arvalid", bus.m_axi_arvalid, 0);
    bus.s_axi_rready = 1'b1;
    step();
    bus.s_axi_rready = 1'b0;
    bus.s_axi_awaddr = 8'h50; bus.s_axi_wdata = 32'h0BAD_0BAD;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    chk("dec_w_bvalid", bus.s_axi_bvalid, 1);
    chk("dec_w_bresp", bus.s_axi_bresp, 3);
    chk("dec_w_m_awvalid", bus.m_axi_awvalid, 0);
    chk("dec_w_m_wvalid", bus.m_axi_wvalid, 0);
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;

    // Write to port2 that never responds -> SLVERR after 64 cycles
    bus.m_axi_awready[2] = 1'b1; bus.m_axi_wready[2] = 1'b1;
    bus.s_axi_awaddr = 8'h20; bus.s_axi_wdata = 32'hDEAD_BEEF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    chk("to_m_awvalid", bus.m_axi_awvalid, 4'b0100);
    n_wait = 0;
    while (bus.s_axi_bvalid !== 1'b1 && n_wait < 200) begin
      step();
      n_wait++;
    end
    chk("to_cycles", n_wait, 64);
    chk("to_bresp", bus.s_axi_bresp, 2);
    chk("to_m_bready", bus.m_axi_bready, 0);
    bus.m_axi_bvalid[2] = 1'b1; bus.m_axi_bresp[2*RW +: RW] = 3'd0;
    step();
    chk("to_late_bready", bus.m_axi_bready, 0);
    chk("to_late_bresp", bus.s_axi_bresp, 2);
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    chk("to_late_ignored", bus.s_axi_bvalid, 0);
    step();
    chk("to_late_ignored2", bus.s_axi_bvalid, 0);
    bus.m_axi_bvalid[2] = 1'b0;
    step();
    bus.m_axi_bvalid[2] = 1'b1;
    bus.s_axi_awaddr = 8'h24; bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    step();
    step();
    chk("to_retry_bvalid", bus.s_axi_bvalid, 1);
    chk("to_retry_bresp", bus.s_axi_bresp, 0);
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    bus.m_axi_awready = '0; bus.m_axi_wready = '0; bus.m_axi_bvalid = '0;

    // Concurrent write to port3 (W handshake one cycle late) and read from port0
    bus.m_axi_awready[3] = 1'b1; bus.m_axi_wready[3] = 1'b0;
    bus.m_axi_bvalid[3] = 1'b1; bus.m_axi_bresp[3*RW +: RW] = 3'd1;
    bus.m_axi_arready[0] = 1'b1; bus.m_axi_rvalid[0] = 1'b1;
    bus.m_axi_rdata[0*DW +: DW] = 32'h1234_5678; bus.m_axi_rresp[0*RW +: RW] = 3'd0;
    bus.s_axi_awaddr = 8'h30; bus.s_axi_wdata = 32'hA5A5_A5A5; bus.s_axi_wstrb = 4'h3;
    bus.s_axi_araddr = 8'h04;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    chk("cc_m_awvalid", bus.m_axi_awvalid, 4'b1000);
    chk("cc_m_wvalid",  bus.m_axi_wvalid, 4'b1000);
    chk("cc_m_arvalid", bus.m_axi_arvalid, 4'b0001);
    chk("cc_m_wdata",   bus.m_axi_wdata[3*DW +: DW], 32'hA5A5_A5A5);
    chk("cc_m_wstrb",   bus.m_axi_wstrb[3*SW +: SW], 4'h3);
    step();
    chk("cc_aw_dropped", bus.m_axi_awvalid, 4'b0000);
    chk("cc_w_held", bus.m_axi_wvalid, 4'b1000);
    chk("cc_m_rready", bus.m_axi_rready, 4'b0001);
    bus.m_axi_wready[3] = 1'b1;
    step();
    chk("cc_rvalid", bus.s_axi_rvalid, 1);
    chk("cc_rdata", bus.s_axi_rdata, 32'h1234_5678);
    chk("cc_m_bready", bus.m_axi_bready, 4'b1000);
    step();
    chk("cc_bvalid", bus.s_axi_bvalid, 1);
    chk("cc_bresp", bus.s_axi_bresp, 1);
    bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
    chk("cc_bvalid_clr", bus.s_axi_bvalid, 0);
    chk("cc_rvalid_clr", bus.s_axi_rvalid, 0);
    bus.m_axi_awready = '0; bus.m_axi_wready = '0; bus.m_axi_bvalid = '0;
    bus.m_axi_arready = '0; bus.m_axi_rvalid = '0;

    // Async reset while write waits on port1 and read waits on port2
    bus.m_axi_awready[1] = 1'b1; bus.m_axi_wready[1] = 1'b1; bus.m_axi_arready[2] = 1'b1;
    bus.s_axi_awaddr = 8'h14; bus.s_axi_araddr = 8'h28;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    step();
    chk("ar_m_bready_pre", bus.m_axi_bready, 4'b0010);
    chk("ar_m_rready_pre", bus.m_axi_rready, 4'b0100);
    rst = 1'b1;
    #1;
    chk("ar_m_bready", bus.m_axi_bready, 0);
    chk("ar_m_rready", bus.m_axi_rready, 0);
    chk("ar_bvalid", bus.s_axi_bvalid, 0);
    chk("ar_rvalid", bus.s_axi_rvalid, 0);
    chk("ar_rdata", bus.s_axi_rdata, 0);
    chk("ar_bresp", bus.s_axi_bresp, 0);
    bus.m_axi_bvalid[1] = 1'b1; bus.m_axi_bresp[1*RW +: RW] = 3'd0;
    step();
    rst = 1'b0;
    step();
    bus.s_axi_awaddr = 8'h10; bus.s_axi_wdata = 32'h0000_0011; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    chk("ar_fresh_m_awvalid", bus.m_axi_awvalid, 4'b0010);
    chk("ar_fresh_m_awaddr", bus.m_axi_awaddr[1*AW +: AW], 8'h10);
    step();
    step();
    chk("ar_fresh_bvalid", bus.s_axi_bvalid, 1);
    chk("ar_fresh_bresp", bus.s_axi_bresp, 0);
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    chk("ar_fresh_bvalid_clr", bus.s_axi_bvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
